// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: pixel-write and frame-status bundle of the WS2812B receiver.
// The master side (the decoder) drives every signal.
interface ws2812_rx_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                  o_wr_en;
   logic [ADDR_WIDTH-1:0] o_wr_addr;
   logic [23:0]           o_wr_data;
   logic                  o_frame_done;
   logic                  o_frame_err;
   logic [ADDR_WIDTH:0]   o_pixel_count;
   logic                  o_busy;

   modport master (
      output o_wr_en, o_wr_addr, o_wr_data,
      output o_frame_done, o_frame_err,
      output o_pixel_count, o_busy
   );

   modport slave (
      input o_wr_en, o_wr_addr, o_wr_data,
      input o_frame_done, o_frame_err,
      input o_pixel_count, o_busy
   );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B NRZ line decoder writing 24-bit GRB pixels to a RAM.
// Frames are delimited by a long low gap; errors are reported per frame.
module ws2812_rx #(
   parameter int ADDR_WIDTH = 5,
   parameter int PIXELS     = 32,
   parameter int MIN_HIGH   = 10,
   parameter int BIT_THRESH = 60,
   parameter int MAX_HIGH   = 150,
   parameter int RESET_CYC  = 5000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_din,
   ws2812_rx_if.master pix
);
   localparam int HW = $clog2(MAX_HIGH + 2);
   localparam int LW = $clog2(RESET_CYC + 1);
   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      SYNC, IDLE, HIGH, LOW
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [HW-1:0]         hcnt_q, hcnt_d;
   logic [LW-1:0]         lcnt_q, lcnt_d;
   logic [23:0]           shreg_q, shreg_d;
   logic [4:0]            bcnt_q, bcnt_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic                  err_q, err_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]           wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic                  ferr_q, ferr_d;
   logic [CW-1:0]         pcnt_q, pcnt_d;

   logic        din_s;
   logic        bit_v;
   logic [23:0] shifted;
   logic        gap_end;

   assign din_s   = sync_q[1];
   assign bit_v   = (hcnt_q >= HW'(BIT_THRESH));
   assign shifted = {shreg_q[22:0], bit_v};
   assign gap_end = (lcnt_q >= LW'(RESET_CYC - 1));
   assign sync_d  = {sync_q[0], i_din};

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      lcnt_d    = lcnt_q;
      shreg_d   = shreg_q;
      bcnt_d    = bcnt_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      pcnt_d    = pcnt_q;
      unique case (state_q)
         SYNC: begin
            if (din_s) begin
               lcnt_d = '0;
            end else if (gap_end) begin
               state_d = IDLE;
               lcnt_d  = '0;
               wcnt_d  = '0;
               bcnt_d  = '0;
               err_d   = 1'b0;
               if (err_q) begin
                  done_d = 1'b1;
                  ferr_d = 1'b1;
                  pcnt_d = wcnt_q;
               end
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (din_s) begin
               state_d = HIGH;
               hcnt_d  = HW'(1);
               wcnt_d  = '0;
            end
         end
         HIGH: begin
            if (din_s) begin
               hcnt_d = hcnt_q + 1'b1;
               // a high longer than MAX_HIGH means the line is stuck
               if (hcnt_q >= HW'(MAX_HIGH)) begin
                  err_d   = 1'b1;
                  state_d = SYNC;
                  lcnt_d  = '0;
               end
            end else begin
               state_d = LOW;
               lcnt_d  = LW'(1);
               if (hcnt_q < HW'(MIN_HIGH)) begin
                  err_d = 1'b1;
               end else begin
                  shreg_d = shifted;
                  if (bcnt_q == 5'd23) begin
                     bcnt_d = '0;
                     if (wcnt_q < CW'(PIXELS)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wcnt_q[ADDR_WIDTH-1:0];
                        wr_data_d = shifted;
                        wcnt_d    = wcnt_q + 1'b1;
                     end
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end
            end
         end
         LOW: begin
            if (din_s) begin
               state_d = HIGH;
               hcnt_d  = HW'(1);
            end else if (gap_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ferr_d  = err_q | (bcnt_q != 5'd0);
               pcnt_d  = wcnt_q;
               wcnt_d  = '0;
               bcnt_d  = '0;
               err_d   = 1'b0;
               lcnt_d  = '0;
            end else begin
               lcnt_d = lcnt_q + 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= SYNC;
         sync_q    <= '0;
         hcnt_q    <= '0;
         lcnt_q    <= '0;
         shreg_q   <= '0;
         bcnt_q    <= '0;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         pcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         hcnt_q    <= hcnt_d;
         lcnt_q    <= lcnt_d;
         shreg_q   <= shreg_d;
         bcnt_q    <= bcnt_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         pcnt_q    <= pcnt_d;
      end
   end

   assign pix.o_wr_en       = wr_en_q;
   assign pix.o_wr_addr     = wr_addr_q;
   assign pix.o_wr_data     = wr_data_q;
   assign pix.o_frame_done  = done_q;
   assign pix.o_frame_err   = ferr_q;
   assign pix.o_pixel_count = pcnt_q;
   assign pix.o_busy        = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receive-side counterpart of the WS2812B driver path. Decodes a single-wire WS2812B NRZ stream (GRB, MSB-first, 24 bits per pixel) back into 24-bit pixel words.
- Writes each decoded pixel into a 32-entry pixel RAM through a simple write port, with the address auto-incrementing from 0 at every frame.
- Used for on-board loopback of the LED output pin and as a frame-capture checker. Clocked at 100 MHz on the Artix-7.

Parameters:
- ADDR_WIDTH, 5, pixel buffer address width.
- PIXELS, 32, maximum pixels captured per frame.
- MIN_HIGH, 10, high pulses shorter than this many cycles are glitches (error).
- BIT_THRESH, 60, high width >= this is a '1', otherwise a '0'.
- MAX_HIGH, 150, high width > this is a stuck-line error.
- RESET_CYC, 5000, consecutive low cycles that end a frame (50 us at 100 MHz).

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_din  in  1  asynchronous serial WS2812B data line.
- o_wr_en  out  1  one-cycle pixel write strobe.
- o_wr_addr  out  ADDR_WIDTH  pixel index within the frame.
- o_wr_data  out  24  decoded GRB word; bit 23 is the first bit received.
- o_frame_done  out  1  one-cycle pulse at frame end.
- o_frame_err  out  1  error status of the ended frame; valid only with o_frame_done.
- o_pixel_count  out  ADDR_WIDTH+1  pixels written in the last frame; saturates at PIXELS; held until the next o_frame_done.
- o_busy  out  1  high in HIGH or LOW state.

Behaviour:
- Reset: one cycle of i_rst_n=0 asynchronously forces all of the following to 0: every output, the counters, the shift register, the bit count, the address, the error-pending flag and both synchronizer flops. The state goes to SYNC.
- Input path: i_din -> 2-FF synchronizer -> din_s. All decode uses din_s only. Latency from an i_din edge to the state reacting is 2 cycles.
- States are SYNC, IDLE, HIGH, LOW.
- SYNC:
  - Counts consecutive din_s=0 cycles; any din_s=1 clears the count.
  - When the count reaches RESET_CYC, go to IDLE.
  - If error-pending is set at that moment: pulse o_frame_done with o_frame_err=1, update o_pixel_count, then clear error-pending, the address and the bit count.
  - This prevents decoding that starts mid-stream.
- IDLE:
  - din_s=1 -> HIGH, with the high counter set to 1 and the address set to 0.
  - o_busy=0.
- HIGH:
  - The high counter increments each cycle din_s=1.
  - If the counter exceeds MAX_HIGH: set error-pending, go to SYNC.
  - On din_s=0:
    - If count < MIN_HIGH: set error-pending; no bit is shifted.
    - Otherwise shift in bit = (count >= BIT_THRESH) at the LSB and increment the bit count.
    - Go to LOW with the low counter set to 1.
- 24th bit:
  - The cycle after the shift, o_wr_en=1 for exactly one cycle, with o_wr_data = the assembled word and o_wr_addr = the current address.
  - Then the address increments and the bit count returns to 0.
  - If PIXELS pixels have already been written this frame, the pixel is dropped: no o_wr_en, no address change, pixel count stays at PIXELS.
- LOW:
  - The low counter increments each cycle din_s=0.
  - din_s=1 -> HIGH with the high counter set to 1. A next bit arriving as soon as the previous low ends is legal.
  - When the low count reaches RESET_CYC, the frame ends:
    - Pulse o_frame_done.
    - o_frame_err = error-pending OR (bit count != 0). A partial pixel is discarded, never written.
    - o_pixel_count = pixels written.
    - Clear the address, bit count and error-pending; go to IDLE.
- Simultaneous events:
  - The 24th-bit write strobe and a new rising edge can fall in the same cycle; both are handled.
  - o_wr_en is never asserted in the same cycle as o_frame_done.
- Reset mid-frame: the partial frame is discarded with no o_frame_done, and decoding restarts in SYNC.
- Counters saturate and never wrap. High counter width covers MAX_HIGH+1; low counter width covers RESET_CYC.

Test Plan:
- After reset: drive i_din low for 5000 cycles, then send 1 pixel 0xA5_3C_0F (T0H=40/T0L=85, T1H=80/T1L=45 cycles), then 6000 low cycles -> one o_wr_en with addr=0, data=0xA53C0F; o_frame_done with o_frame_err=0 and o_pixel_count=1.
- Full frame: 32 distinct pixels (e.g. the LED pattern table words), then reset gap -> 32 writes at addr 0..31 with matching data; o_pixel_count=32, o_frame_err=0.
- Overflow: 34 pixels -> exactly 32 writes; pixels 33 and 34 are dropped; o_pixel_count=32.
- Partial pixel: 24 bits then 10 bits, then reset gap -> 1 write; o_frame_done with o_frame_err=1 and o_pixel_count=1.
- Glitch and stuck line: a 5-cycle high pulse mid-pixel -> o_frame_err=1 at frame end. In a separate run, hold high for 200 cycles -> return to SYNC; after 5000 low cycles, o_frame_done with o_frame_err=1.
- Start mid-stream, then reset: start i_din mid-frame with no preceding low gap -> no writes until a 5000-cycle low is seen. Assert i_rst_n=0 mid-pixel -> all outputs 0 immediately; no o_frame_done is emitted for the aborted frame.
